// File: rtl/peripheral_bus_if.sv
// CPU data-memory port as seen by memory-mapped peripherals.
// The master drives the strobes, address and store data; the slave returns read data.
interface peripheral_bus_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output MemRead, MemWrite, address, write_data,
        input  read_data
    );

    modport slave (
        input  MemRead, MemWrite, address, write_data,
        output read_data
    );
endinterface

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral block: reloadable timer with interrupt, LED and
// 7-segment registers, and a free-running systick, decoded beside data memory.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                reset,
    peripheral_bus_if.slave     bus,
    output logic                irq,
    output logic [7:0]          leds,
    output logic [11:0]         digits
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned DIG_W  = 12;
    localparam int unsigned TCON_W = 3;

    typedef enum logic [2:0] {
        REG_TH      = 3'd0,
        REG_TL      = 3'd1,
        REG_TCON    = 3'd2,
        REG_LED     = 3'd3,
        REG_DIGITS  = 3'd4,
        REG_SYSTICK = 3'd5
    } reg_sel_e;

    logic [DATA_W-1:0] th_q, th_d;
    logic [DATA_W-1:0] tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DIG_W-1:0]  digits_q, digits_d;
    logic [DATA_W-1:0] systick_q, systick_d;

    logic              hit_c;
    reg_sel_e          sel_c;
    logic              wr_c;
    logic              ovf_c;
    logic              irq_set_c;
    logic [DATA_W-1:0] read_c;
    logic              unused_addr;

    assign unused_addr = &{1'b0, bus.address[1:0]};

    assign hit_c     = (bus.address[31:5] == BASE_ADDR[31:5]) && (bus.address[4:2] <= 3'd5);
    assign sel_c     = reg_sel_e'(bus.address[4:2]);
    assign wr_c      = bus.MemWrite && hit_c;
    assign ovf_c     = tcon_q[0] && (tl_q == {DATA_W{1'b1}});
    assign irq_set_c = ovf_c && tcon_q[1];

    // Combinational read mux; zero whenever the window is not read.
    always_comb begin
        read_c = '0;
        if (bus.MemRead && hit_c) begin
            case (sel_c)
                REG_TH:      read_c = th_q;
                REG_TL:      read_c = tl_q;
                REG_TCON:    read_c = DATA_W'(tcon_q);
                REG_LED:     read_c = DATA_W'(led_q);
                REG_DIGITS:  read_c = DATA_W'(digits_q);
                REG_SYSTICK: read_c = systick_q;
                default:     read_c = '0;
            endcase
        end
    end

    assign bus.read_data = read_c;

    // Timer update first, then CPU writes override; an interrupt set is never lost.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digits_d  = digits_q;
        systick_d = systick_q + DATA_W'(1);

        if (tcon_q[0]) begin
            tl_d = ovf_c ? th_q : tl_q + DATA_W'(1);
        end
        if (irq_set_c) begin
            tcon_d[2] = 1'b1;
        end

        if (wr_c) begin
            case (sel_c)
                REG_TH:     th_d     = bus.write_data;
                REG_TL:     tl_d     = bus.write_data;
                REG_TCON:   tcon_d   = {bus.write_data[2] | irq_set_c, bus.write_data[1:0]};
                REG_LED:    led_d    = bus.write_data[LED_W-1:0];
                REG_DIGITS: digits_d = bus.write_data[DIG_W-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digits_q  <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
        end
    end

    assign irq    = tcon_q[2];
    assign leds   = led_q;
    assign digits = digits_q;

endmodule
